// File: rtl/cascade_controller.sv
// Runs the Haar cascade for one window: fetches stage headers, drives the stage evaluator, reports a verdict.
// Latency: 5 cycles per stage plus evaluator time; result 1 cycle after the decisive se_done, timeout or n=0 accept.
// Backpressure: win_ready only while idle; result is held until res_ready, so no new window enters meanwhile.
module cascade_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 25,
    parameter int STAGE_AW   = 8,
    parameter int TIMEOUT    = 65535,
    parameter int TAG_W      = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         win_valid,
    output logic                         win_ready,
    input  logic [TAG_W-1:0]             win_tag,
    input  logic [7:0]                   cfg_num_stages,
    output logic [STAGE_AW-1:0]          st_addr,
    input  logic [DATA_WIDTH-1:0]        st_data,
    output logic                         se_start,
    output logic [13:0]                  se_base_addr,
    output logic [15:0]                  se_num_classifiers,
    output logic signed [DATA_WIDTH-1:0] se_threshold,
    input  logic                         se_passed,
    input  logic                         se_done,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         res_face,
    output logic [7:0]                   res_stages,
    output logic                         res_err,
    output logic [TAG_W-1:0]             res_tag,
    output logic [15:0]                  face_count
);

    localparam int                WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT - 1);
    localparam logic [7:0]        MAX_STAGES = 8'(NUM_STAGES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          fcnt;
    logic [7:0]          stage_idx;
    logic [7:0]          num_run;
    logic [7:0]          pass_cnt;
    logic [WD_W-1:0]     wdog;
    logic [7:0]          cfg_clamped;
    logic [STAGE_AW-1:0] stage_base;
    logic                win_acc;
    logic                last_stage;
    logic                wd_expire;

    assign win_acc     = win_valid && win_ready;
    assign cfg_clamped = (cfg_num_stages > MAX_STAGES) ? MAX_STAGES : cfg_num_stages;
    assign last_stage  = (stage_idx + 8'd1) == num_run;
    assign wd_expire   = (wdog == WD_LIMIT);
    assign stage_base  = STAGE_AW'(int'(stage_idx) * 3);

    // Reads for word0..word2 go out on c0..c2; the registered ROM returns each one cycle later.
    assign st_addr   = (state == S_FETCH && fcnt != 2'd3) ? stage_base + STAGE_AW'(fcnt) : '0;
    assign se_start  = (state == S_START);
    assign res_valid = (state == S_RESULT);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (win_acc) begin
                    state_nxt = (cfg_num_stages == 8'd0) ? S_RESULT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (fcnt == 2'd3) begin
                    state_nxt = S_START;
                end
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                // A done arriving in the expiry cycle wins over the watchdog.
                if (se_done) begin
                    state_nxt = (se_passed && !last_stage) ? S_FETCH : S_RESULT;
                end else if (wd_expire) begin
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            win_ready          <= 1'b0;
            fcnt               <= 2'd0;
            stage_idx          <= 8'd0;
            num_run            <= 8'd0;
            pass_cnt           <= 8'd0;
            wdog               <= '0;
            se_base_addr       <= 14'd0;
            se_num_classifiers <= 16'd0;
            se_threshold       <= '0;
            res_face           <= 1'b0;
            res_stages         <= 8'd0;
            res_err            <= 1'b0;
            res_tag            <= '0;
            face_count         <= 16'd0;
        end else begin
            state     <= state_nxt;
            win_ready <= (state_nxt == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (win_acc) begin
                        res_tag    <= win_tag;
                        num_run    <= cfg_clamped;
                        stage_idx  <= 8'd0;
                        pass_cnt   <= 8'd0;
                        fcnt       <= 2'd0;
                        res_face   <= 1'b1;
                        res_stages <= 8'd0;
                        res_err    <= 1'b0;
                    end
                end
                S_FETCH: begin
                    fcnt <= fcnt + 2'd1;
                    case (fcnt)
                        2'd1:    se_base_addr       <= st_data[13:0];
                        2'd2:    se_num_classifiers <= st_data[15:0];
                        2'd3:    se_threshold       <= $signed(st_data);
                        default: ;
                    endcase
                end
                S_START: wdog <= '0;
                S_WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (se_done) begin
                        if (se_passed) begin
                            pass_cnt <= pass_cnt + 8'd1;
                            if (last_stage) begin
                                res_face   <= 1'b1;
                                res_stages <= pass_cnt + 8'd1;
                            end else begin
                                stage_idx <= stage_idx + 8'd1;
                            end
                        end else begin
                            res_face   <= 1'b0;
                            res_stages <= pass_cnt;
                        end
                    end else if (wd_expire) begin
                        res_face   <= 1'b0;
                        res_err    <= 1'b1;
                        res_stages <= pass_cnt;
                    end
                end
                S_RESULT: begin
                    if (res_ready && res_face && face_count != 16'hFFFF) begin
                        face_count <= face_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cascade_controller.md
# cascade_controller

Sequences the Haar cascade for one detection window at a time. It fetches each stage's header from the stage table ROM, drives one `stage_evaluator` per stage, and stops at the first rejected stage. It returns a per-window verdict with stage count and error flag, and keeps a saturating face counter. It sits between the window scanner (upstream) and the shared stage evaluator.

## Interface
- `DATA_WIDTH`, 32: stage table word and threshold width.
- `NUM_STAGES`, 25: maximum stages in the cascade; clamp value for `cfg_num_stages`.
- `STAGE_AW`, 8: stage table address width.
- `TIMEOUT`, 65535: watchdog limit, in cycles, for one stage evaluation.
- `TAG_W`, 20: window tag width (x,y packed).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `win_valid` in 1: window available.
- `win_ready` out 1: controller idle, accepting a window.
- `win_tag` in TAG_W: window tag, passed through to the result.
- `cfg_num_stages` in 8: stages to run; sampled on window accept.
- `st_addr` out STAGE_AW: stage table address.
- `st_data` in DATA_WIDTH: stage table data, registered ROM with 1-cycle latency.
- `se_start` out 1: one-cycle start pulse to the stage evaluator.
- `se_base_addr` out 14: classifier base address for the stage.
- `se_num_classifiers` out 16: classifier count for the stage.
- `se_threshold` out DATA_WIDTH signed: stage threshold.
- `se_passed` in 1: stage verdict, valid with `se_done`.
- `se_done` in 1: stage finished, one-cycle pulse.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed.
- `res_face` out 1: window passed all requested stages.
- `res_stages` out 8: count of stages passed.
- `res_err` out 1: watchdog timeout occurred.
- `res_tag` out TAG_W: tag of the accepted window.
- `face_count` out 16: faces reported; saturates at 0xFFFF.

## Operation
- Stage table layout: stage s occupies addresses 3s, 3s+1, 3s+2.
  - word0[13:0]: base address.
  - word1[15:0]: classifier count.
  - word2: signed threshold.
- States: IDLE, FETCH, START, WAIT, RESULT.
- IDLE:
  - `win_ready`=1.
  - On `win_valid`&&`win_ready`: latch `win_tag`; latch n = min(`cfg_num_stages`, NUM_STAGES); clear stage index s and pass count.
  - If n=0, go directly to RESULT with face=1, stages=0. Otherwise go to FETCH.
- FETCH (4 cycles, pipelined reads):
  - c0: `st_addr`=3s.
  - c1: `st_addr`=3s+1; latch word0.
  - c2: `st_addr`=3s+2; latch word1.
  - c3: latch word2. Then go to START.
- START: `se_start`=1 for exactly one cycle. The `se_*` configuration outputs are held stable from START until `se_done` is received. Clear the watchdog. Go to WAIT.
- WAIT: watchdog increments each cycle.
  - `se_done`&&`se_passed`: pass count +1. If s+1==n, go to RESULT with face=1; otherwise s+1, go to FETCH.
  - `se_done`&&!`se_passed`: go to RESULT with face=0, stages=pass count (early reject).
  - Watchdog reaches TIMEOUT without `se_done`: go to RESULT with face=0, err=1.
  - If `se_done` arrives in the timeout cycle, `se_done` takes priority and err stays 0.
  - `se_done` outside WAIT is ignored.
- RESULT:
  - `res_valid`=1; result fields are held stable until `res_valid`&&`res_ready`.
  - On handshake: if `res_face`=1, `face_count` increments (saturates at 0xFFFF, no wrap). Go to IDLE.

## Timing
- Reset (`rst_n`=0): all outputs 0, including `win_ready`, `face_count` and `st_addr`. State is IDLE. `win_ready` rises on the first clock edge after reset release.
- Reset asserted mid-window: no result is emitted and `face_count` keeps its reset value of 0.
- Per-stage overhead: 4 FETCH cycles + 1 START cycle, plus the evaluator's latency.
- Result timing: `res_valid` rises on the cycle after the decisive `se_done` (or timeout). It rises 1 cycle after accept when n=0.
- Back-to-back windows:
  - `win_ready` returns 1 the cycle after the result handshake.
  - No window is accepted while `res_valid`=1.
- `se_start` is never asserted outside START. There is exactly one pulse per stage.

## Test plan
- 3-stage table, evaluator model passes all stages, `cfg_num_stages`=3, tag 0x12345 -> `res_face`=1, `res_stages`=3, `res_err`=0, `res_tag`=0x12345, `face_count`=1. The `st_addr` sequence is 0..8.
- Stage 1 fails (`se_passed`=0) with n=3 -> `res_face`=0, `res_stages`=1. Exactly 2 `se_start` pulses, and `st_addr` never reaches 6.
- Evaluator never asserts `se_done`, TIMEOUT=16 -> `res_err`=1, `res_face`=0, `res_valid` 17 cycles after START. Repeat with `se_done` in the expiry cycle -> `res_err`=0.
- `cfg_num_stages`=0 -> `res_face`=1, `res_stages`=0, no `se_start`. `cfg_num_stages`=200 with NUM_STAGES=25 -> 25 stages are run.
- `res_ready` held low for 10 cycles -> result fields stable, `win_ready`=0 throughout, no double increment of `face_count`. With `face_count` preloaded near 0xFFFF, two face results -> count stays at 0xFFFF.
- `rst_n` pulsed low during WAIT of stage 2 -> all outputs 0 immediately, `win_ready`=1 one edge after release, and the next window runs from stage 0.
